// File: rtl/div_pkg.sv
// Shared decode constants, FSM state type and op-decode helpers for the divide sequencer.
// Pure declarations, no timing.
// No flow control.
package div_pkg;

  localparam logic [5:0] ALU_DIV   = 6'b100011;
  localparam logic [5:0] ALU_DIVU  = 6'b100100;
  localparam logic [5:0] ALU_REM   = 6'b100101;
  localparam logic [5:0] ALU_REMU  = 6'b100110;
  localparam logic [5:0] ALU_DIVW  = 6'b101000;
  localparam logic [5:0] ALU_DIVUW = 6'b101001;
  localparam logic [5:0] ALU_REMW  = 6'b101010;
  localparam logic [5:0] ALU_REMUW = 6'b101011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [5:0] code);
    return (code >= ALU_DIV && code <= ALU_REMU) || (code >= ALU_DIVW && code <= ALU_REMUW);
  endfunction

  function automatic logic is_signed(input logic [5:0] code);
    return code == ALU_DIV || code == ALU_REM || code == ALU_DIVW || code == ALU_REMW;
  endfunction

  function automatic logic is_rem(input logic [5:0] code);
    return code == ALU_REM || code == ALU_REMU || code == ALU_REMW || code == ALU_REMUW;
  endfunction

  function automatic logic is_word(input logic [5:0] code);
    return code == ALU_DIVW || code == ALU_DIVUW || code == ALU_REMW || code == ALU_REMUW;
  endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// Latency: one step per enabled cycle; next-step values are exposed so the caller can register the final result.
// No backpressure: load and step are driven by the owning sequencer.
module div_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   diff;

  // Shift next dividend bit into the partial remainder and subtract if it fits (no borrow).
  always_comb begin
    part = {rem, quo[WIDTH-1]};
    diff = part - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = part[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // Quotient register starts holding the dividend and is shifted out as quotient bits shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV64M divide/remainder controller: decode, special cases, sign/width fix-up, stall.
// Latency: accept in cycle 0, result strobe in cycle N+1 (N = 64 or 32), cycle 1 for div-by-zero/overflow.
// Holds stall while accepting and calculating; no accept while busy; flush aborts with no result.
module div_sequencer
  import div_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int W_WIDTH        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [5:0]                in_alu_control,
  input  logic [BUS_DATA_WIDTH-1:0] in_data1,
  input  logic [BUS_DATA_WIDTH-1:0] in_data2,
  input  logic [4:0]                in_dest_reg,
  input  logic                      flush,
  output logic                      ready,
  output logic                      stall,
  output logic                      out_valid,
  output logic [BUS_DATA_WIDTH-1:0] out_result,
  output logic [4:0]                out_dest_reg
);

  localparam int BW = BUS_DATA_WIDTH;
  localparam int WW = W_WIDTH;
  localparam int XW = BW - WW;
  localparam int CW = $clog2(BW + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rem_q, word_q, negq_q, negr_q, done_q;
  logic [4:0]      dest_q;

  logic            op_div, op_signed, op_rem, op_word, accept, step;
  logic            neg_a, neg_b, div_zero, ovf, neg_res;
  logic [WW-1:0]   a_lo, b_lo, abs_a_lo, abs_b_lo, sel_lo, fix_lo;
  logic [BW-1:0]   abs_a, abs_b, core_dvd, core_dvs, dvd_ext, spec_res;
  logic [BW-1:0]   quo_nxt, rem_nxt, sel_full, fix_res;
  logic [CW-1:0]   last_cnt;

  // Decode the presented op: operand magnitudes at operand width, and the results that bypass the core.
  always_comb begin
    op_div    = is_div(in_alu_control);
    op_signed = is_signed(in_alu_control);
    op_rem    = is_rem(in_alu_control);
    op_word   = is_word(in_alu_control);
    a_lo      = in_data1[WW-1:0];
    b_lo      = in_data2[WW-1:0];
    neg_a     = op_signed & (op_word ? a_lo[WW-1] : in_data1[BW-1]);
    neg_b     = op_signed & (op_word ? b_lo[WW-1] : in_data2[BW-1]);
    abs_a_lo  = neg_a ? -a_lo : a_lo;
    abs_b_lo  = neg_b ? -b_lo : b_lo;
    abs_a     = neg_a ? -in_data1 : in_data1;
    abs_b     = neg_b ? -in_data2 : in_data2;
    // W dividends sit in the upper half so the core needs only WW steps.
    core_dvd  = op_word ? {abs_a_lo, {XW{1'b0}}} : abs_a;
    core_dvs  = op_word ? {{XW{1'b0}}, abs_b_lo} : abs_b;
    dvd_ext   = op_word ? {{XW{a_lo[WW-1]}}, a_lo} : in_data1;
    div_zero  = op_word ? (b_lo == '0) : (in_data2 == '0);
    ovf       = op_signed & (op_word ? (a_lo == {1'b1, {(WW-1){1'b0}}} && b_lo == '1)
                                     : (in_data1 == {1'b1, {(BW-1){1'b0}}} && in_data2 == '1));
    if (div_zero) spec_res = op_rem ? dvd_ext : '1;
    else          spec_res = op_rem ? '0 : dvd_ext;
    accept    = (state == IDLE) && in_valid && op_div && !flush;
    step      = (state == CALC);
    stall     = ((state == IDLE) && in_valid && op_div) || (state == CALC);
    ready     = (state == IDLE);
    out_valid = done_q & ~flush;
    last_cnt  = word_q ? CW'(WW - 1) : CW'(BW - 1);
  end

  // Sign and width correction of the core's final-step values.
  always_comb begin
    sel_full = rem_q ? rem_nxt : quo_nxt;
    sel_lo   = sel_full[WW-1:0];
    neg_res  = rem_q ? negr_q : negq_q;
    fix_lo   = neg_res ? -sel_lo : sel_lo;
    fix_res  = word_q ? {{XW{fix_lo[WW-1]}}, fix_lo} : (neg_res ? -sel_full : sel_full);
  end

  div_core #(.WIDTH(BW)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .dividend (core_dvd),
    .divisor  (core_dvs),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Control FSM with registered result outputs; flush overrides everything but reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_q        <= 1'b0;
      word_q       <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      dest_q       <= '0;
      done_q       <= 1'b0;
      out_result   <= '0;
      out_dest_reg <= '0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            rem_q  <= op_rem;
            word_q <= op_word;
            negq_q <= neg_a ^ neg_b;
            negr_q <= neg_a;
            dest_q <= in_dest_reg;
            if (div_zero || ovf) begin
              state        <= DONE;
              done_q       <= 1'b1;
              out_result   <= spec_res;
              out_dest_reg <= in_dest_reg;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            state        <= DONE;
            done_q       <= 1'b1;
            out_result   <= fix_res;
            out_dest_reg <= dest_q;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with an arithmetic reference model and a per-cycle compare process.
module tb_div_sequencer;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  in_alu_control = '0;
  logic [63:0] in_data1 = '0;
  logic [63:0] in_data2 = '0;
  logic [4:0]  in_dest_reg = '0;
  logic        ready, stall, out_valid;
  logic [63:0] out_result;
  logic [4:0]  out_dest_reg;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  // Expected activity windows of the current op, in bench cycle numbers.
  int acc_cyc = -100;
  int stall_last = -100;
  int busy_last = -100;
  int valid_cyc = -100;
  logic [63:0] exp_res = '0;
  logic [4:0]  exp_dest = '0;

  div_sequencer #(.BUS_DATA_WIDTH(64), .W_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_control(in_alu_control),
    .in_data1(in_data1), .in_data2(in_data2), .in_dest_reg(in_dest_reg), .flush(flush),
    .ready(ready), .stall(stall), .out_valid(out_valid), .out_result(out_result),
    .out_dest_reg(out_dest_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic bit w_op(input logic [5:0] c);
    return c == ALU_DIVW || c == ALU_DIVUW || c == ALU_REMW || c == ALU_REMUW;
  endfunction

  function automatic bit s_op(input logic [5:0] c);
    return c == ALU_DIV || c == ALU_REM || c == ALU_DIVW || c == ALU_REMW;
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] c, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    sa = a; sb = b; ua32 = a[31:0]; ub32 = b[31:0]; sa32 = ua32; sb32 = ub32;
    r = '0; r32 = '0;
    case (c)
      ALU_DIV:  if (b == 0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = a;
                else r = 64'(sa / sb);
      ALU_REM:  if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = 0;
                else r = 64'(sa % sb);
      ALU_DIVU: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      ALU_REMU: r = (b == 0) ? a : a % b;
      ALU_DIVW: if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                else r32 = 32'(sa32 / sb32);
      ALU_REMW: if (ub32 == 0) r32 = ua32;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 0;
                else r32 = 32'(sa32 % sb32);
      ALU_DIVUW: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
      ALU_REMUW: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
      default: r = '0;
    endcase
    if (w_op(c)) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Cycles from accept to result strobe.
  function automatic int lat_of(input logic [5:0] c, input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (w_op(c)) begin
      zero = (b[31:0] == 0);
      ovf  = s_op(c) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 0);
      ovf  = s_op(c) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    end
    if (zero || ovf) return 1;
    return w_op(c) ? 33 : 65;
  endfunction

  // Per-cycle comparison of all status outputs and, when due, the result.
  always @(negedge clk) begin
    logic ev;
    ev = (cyc == valid_cyc);
    check("stall", {63'd0, stall}, {63'd0, (cyc >= acc_cyc && cyc <= stall_last)});
    check("ready", {63'd0, ready}, {63'd0, !(cyc > acc_cyc && cyc <= busy_last)});
    check("out_valid", {63'd0, out_valid}, {63'd0, ev});
    if (ev) begin
      check("out_result", out_result, exp_res);
      check("out_dest_reg", {59'd0, out_dest_reg}, {59'd0, exp_dest});
    end
  end

  // Present an op for one cycle and record its expected timing and result.
  task automatic start_op(input string name, input logic [5:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] d, input logic [63:0] lit);
    int lat;
    lat = lat_of(c, a, b);
    check({"model_", name}, model(c, a, b), lit);
    in_valid = 1'b1; in_alu_control = c; in_data1 = a; in_data2 = b; in_dest_reg = d;
    acc_cyc = cyc; valid_cyc = cyc + lat; stall_last = valid_cyc - 1; busy_last = valid_cyc;
    exp_res = model(c, a, b); exp_dest = d;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  // Run an op to completion; returns in the first cycle a new op may be accepted.
  task automatic run_op(input string name, input logic [5:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d, input logic [63:0] lit);
    int lat;
    lat = lat_of(c, a, b);
    start_op(name, c, a, b, d, lit);
    repeat (lat) @(posedge clk);
    #1;
  endtask

  logic [5:0] bad_codes [3] = '{6'b001100, 6'b100111, 6'b100010};

  initial begin
    #2;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_dest", {59'd0, out_dest_reg}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    check("lat_64", 64'(lat_of(ALU_DIVU, 64'd100, 64'd7)), 64'd65);
    check("lat_w", 64'(lat_of(ALU_REMW, 64'h1_8000_0005, 64'd2)), 64'd33);
    check("lat_zero", 64'(lat_of(ALU_DIVW, 64'd5, 64'd0)), 64'd1);
    check("lat_ovf", 64'(lat_of(ALU_REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF)), 64'd1);

    run_op("divu", ALU_DIVU, 64'd100, 64'd7, 5'd1, 64'd14);
    run_op("remu", ALU_REMU, 64'd100, 64'd7, 5'd2, 64'd2);
    run_op("div_neg", ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_neg", ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remw", ALU_REMW, 64'h1_8000_0005, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divw_z", ALU_DIVW, 64'd5, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_z", ALU_REMU, 64'h1234, 64'd0, 5'd7, 64'h1234);
    run_op("div_ovf", ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h8000_0000_0000_0000);
    run_op("remw_ovf", ALU_REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0);
    run_op("divuw_sx", ALU_DIVUW, 64'hFFFF_FFFE, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divw_neg", ALU_DIVW, 64'h1234_5678_FFFF_FF9C, 64'd7, 5'd11, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("remuw", ALU_REMUW, 64'h8000_0007, 64'h10, 5'd12, 64'd7);
    run_op("div_negb", ALU_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("rem_negb", ALU_REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, 64'd2);
    run_op("divw_ovf", ALU_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'hFFFF_FFFF_8000_0000);

    // Flush in cycle 10 of a divu, then a divuw accepted in cycle 11.
    start_op("divu_fl", ALU_DIVU, 64'd1000, 64'd3, 5'd16, 64'd333);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; stall_last = cyc; busy_last = cyc; valid_cyc = -100;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_ready", {63'd0, ready}, 64'd1);
    check("flush_stall", {63'd0, stall}, 64'd0);
    run_op("divuw_af", ALU_DIVUW, 64'd9, 64'd3, 5'd17, 64'd3);

    // Asynchronous reset in cycle 20 of a div.
    start_op("div_rst", ALU_DIV, 64'd1000, 64'd10, 5'd18, 64'd100);
    repeat (19) @(posedge clk);
    #1;
    stall_last = cyc - 1; busy_last = cyc - 1; valid_cyc = -100;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {63'd0, ready}, 64'd1);
    check("mid_rst_stall", {63'd0, stall}, 64'd0);
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_result", out_result, 64'd0);
    check("mid_rst_dest", {59'd0, out_dest_reg}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Codes outside the divide set are ignored.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_alu_control = bad_codes[i]; in_data1 = 64'd100; in_data2 = 64'd7;
      #1 check("bad_code_stall", {63'd0, stall}, 64'd0);
      repeat (3) @(posedge clk);
      #1 check("bad_code_ready", {63'd0, ready}, 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle integer divide/remainder controller for the execute stage. It takes the RV64M divide-family ops (div, divu, rem, remu, divw, divuw, remw, remuw) away from the single-cycle ALU. It runs a radix-2 restoring divider one quotient bit per cycle and holds the pipeline stall line while busy. It returns the sign-corrected, width-corrected result with the destination register tag.

Parameters:
BUS_DATA_WIDTH, 64, operand/result width; also the iteration count for non-W ops.
W_WIDTH, 32, operand width and iteration count for W ops.

Ports:
clk  input  1  pipeline clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  execute stage presents a divide-family op this cycle.
in_alu_control  input  6  ALU control code; only 6'b100011..6'b100110 and 6'b101000..6'b101011 are accepted.
in_data1  input  BUS_DATA_WIDTH  dividend (after forwarding mux).
in_data2  input  BUS_DATA_WIDTH  divisor (after forwarding mux).
in_dest_reg  input  5  destination register tag.
flush  input  1  abort the in-flight op (branch mispredict/exception).
ready  output  1  high only in IDLE.
stall  output  1  freeze IF/ID/EX pipeline registers.
out_valid  output  1  one-cycle result strobe.
out_result  output  BUS_DATA_WIDTH  quotient or remainder.
out_dest_reg  output  5  tag of out_result.

Behaviour:
- States: IDLE, CALC, DONE. Reset gives IDLE, out_valid=0, out_result=0, out_dest_reg=0, stall=0, ready=1, iteration counter=0.
- Accept: when IDLE && in_valid && the op is a divide code, latch the op, operands, sign flags and tag at the edge. Codes outside the set are ignored and the block stays in IDLE.
- stall (combinational): 1 when IDLE && in_valid && divide code, and 1 throughout CALC. It is 0 in DONE, so the pipeline advances in the same cycle it captures out_result.
- Latency: accept edge ends cycle 0. CALC occupies cycles 1..N, with N = BUS_DATA_WIDTH for 64-bit ops and N = W_WIDTH for W ops. DONE is cycle N+1; out_valid=1 for exactly that cycle, then IDLE.
- Width rules:
  - W ops use in_data[31:0] only; signed W ops sign-extend from bit 31.
  - The result of every W op is sign-extended from bit 31 to BUS_DATA_WIDTH, including divuw/remuw.
- Signed ops: divide absolute values.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
- Special cases skip CALC (IDLE, then DONE in cycle 1):
  - Divisor == 0: quotient = all ones; remainder = dividend (W: low 32 bits sign-extended).
  - Signed overflow (most-negative / -1, at operand width): quotient = dividend; remainder = 0.
- flush: in CALC or DONE, go to IDLE at the next edge with no out_valid. If flush arrives in the same cycle as an accept, the accept is suppressed. flush has priority over everything except reset.
- reset mid-operation: immediately return to IDLE with all outputs at their reset values.
- Back-to-back: a new op can be accepted in the cycle after DONE; there is no accept while in DONE.
- out_result and out_dest_reg hold their last value outside DONE; consumers qualify them with out_valid.

Decomposition:
- Package div_pkg:
  - localparams for the eight ALU control codes.
  - State enum typedef {IDLE, CALC, DONE}.
  - Op-decode helper functions (is_div, is_signed, is_rem, is_word).
- One sub-module, div_core: the shift/subtract datapath (remainder register, quotient register, step enable).
  - It is sized BUS_DATA_WIDTH.
  - W ops are pre-shifted into the upper half so the core's step count equals N.
- div_sequencer owns the FSM, iteration counter, special-case detection, sign fix-up and stall.

Test Plan:
- divu 100 / 7: stall high for cycles 0..64; out_valid only in cycle 65; out_result = 14. Then remu 100 / 7 gives 2.
- div -7 / 2 gives 0xFFFF_FFFF_FFFF_FFFD (-3); rem -7 / 2 gives 0xFFFF_FFFF_FFFF_FFFF (-1); remw 0x1_8000_0005 / 2 gives 0xFFFF_FFFF_FFFF_FFFF with out_valid in cycle 33.
- Division by zero:
  - divw 5 / 0 gives 0xFFFF_FFFF_FFFF_FFFF in cycle 1.
  - remu 0x1234 / 0 gives 0x1234 in cycle 1.
- Signed overflow:
  - div 0x8000_0000_0000_0000 / -1 gives 0x8000_0000_0000_0000 in cycle 1.
  - remw 0x8000_0000 / -1 gives 0.
- flush in cycle 10 of a divu: state goes to IDLE at cycle 11, stall drops, no out_valid. A new divuw 9 / 3 accepted in cycle 11 gives 3 with out_valid in cycle 44.
- Assert reset in cycle 20 of a div: ready=1, stall=0, out_valid=0 at once. A non-divide code (6'b001100) with in_valid never asserts stall or out_valid.
